// File: rtl/ttc_cfg_sequencer6.sv
// ttc_cfg_sequencer6
// Configuration sequencer for one TTC counter channel. Arbitrates round-robin
// between two requesters (0 = host register path, 1 = power manager). It
// latches the winning packet and replays it into the counter's register write
// port in a fixed order: disable, interval, match1..3, final control. When the
// final control value requests a restart, it waits for the counter to clear
// the restart bit. If that does not happen within TIMEOUT cycles, the
// transaction completes with err6 set.
//
// Ports
//   pclk6, n_p_reset6           clock, async active-low reset
//   req6[1:0]                   per-requester request, held until done6
//   cfg_*0_6 / cfg_*1_6         requester packets (mask, ctrl, interval, match)
//   cntr_ctrl_reg_in6[6:0]      live counter control readback
//   pwdata6[15:0], *_reg_sel6   counter register write data and strobes
//   gnt6, done6, err6, busy6    handshake and status (all registered)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a request; arbitrates and latches the packet
// DISABLE  | writes readback with enable forced off, restart cleared
// WR_INT   | writes interval register
// WR_M1    | writes match 1 register
// WR_M2    | writes match 2 register
// WR_M3    | writes match 3 register
// WR_CTRL  | writes final control value
// WAIT_RST | waits for counter to consume restart (bit4 low) or timeout
// DONE     | completion pulse to the winner
module ttc_cfg_sequencer6 #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        pclk6,
  input  logic        n_p_reset6,
  input  logic [1:0]  req6,
  input  logic [4:0]  cfg_mask0_6,
  input  logic [4:0]  cfg_mask1_6,
  input  logic [6:0]  cfg_ctrl0_6,
  input  logic [6:0]  cfg_ctrl1_6,
  input  logic [15:0] cfg_int0_6,
  input  logic [15:0] cfg_m1_0_6,
  input  logic [15:0] cfg_m2_0_6,
  input  logic [15:0] cfg_m3_0_6,
  input  logic [15:0] cfg_int1_6,
  input  logic [15:0] cfg_m1_1_6,
  input  logic [15:0] cfg_m2_1_6,
  input  logic [15:0] cfg_m3_1_6,
  input  logic [6:0]  cntr_ctrl_reg_in6,
  output logic [15:0] pwdata6,
  output logic        cntr_ctrl_reg_sel6,
  output logic        interval_reg_sel6,
  output logic        match_1_reg_sel6,
  output logic        match_2_reg_sel6,
  output logic        match_3_reg_sel6,
  output logic [1:0]  gnt6,
  output logic [1:0]  done6,
  output logic        err6,
  output logic        busy6
);

  typedef enum logic [3:0] {
    IDLE, DISABLE, WR_INT, WR_M1, WR_M2, WR_M3, WR_CTRL, WAIT_RST, DONE
  } state_t;

  state_t      state, state_nxt;
  logic        ptr;
  logic        win_q, win_n;
  logic [4:0]  mask_q, mask_n;
  logic [6:0]  ctrl_q, ctrl_n;
  logic [15:0] int_q, int_n, m1_q, m1_n, m2_q, m2_n, m3_q, m3_n;
  logic [7:0]  tmo_cnt;
  logic [4:0]  sel_q, sel_n;
  logic [15:0] data_n;

  // First pending write in sequence order; callers clear bits already done.
  function automatic state_t first_wr(input logic [4:0] m);
    if (m[1])      first_wr = WR_INT;
    else if (m[2]) first_wr = WR_M1;
    else if (m[3]) first_wr = WR_M2;
    else if (m[4]) first_wr = WR_M3;
    else if (m[0]) first_wr = WR_CTRL;
    else           first_wr = DONE;
  endfunction

  // In IDLE the packet comes straight from the winner so the first write
  // state can be decoded on the grant edge; afterwards the latched copy rules.
  always_comb begin
    win_n  = win_q;
    mask_n = mask_q;
    ctrl_n = ctrl_q;
    int_n  = int_q;
    m1_n   = m1_q;
    m2_n   = m2_q;
    m3_n   = m3_q;
    if (state == IDLE) begin
      win_n  = (req6 == 2'b11) ? ptr : req6[1];
      mask_n = win_n ? cfg_mask1_6 : cfg_mask0_6;
      ctrl_n = win_n ? cfg_ctrl1_6 : cfg_ctrl0_6;
      int_n  = win_n ? cfg_int1_6  : cfg_int0_6;
      m1_n   = win_n ? cfg_m1_1_6  : cfg_m1_0_6;
      m2_n   = win_n ? cfg_m2_1_6  : cfg_m2_0_6;
      m3_n   = win_n ? cfg_m3_1_6  : cfg_m3_0_6;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|req6) state_nxt = (|mask_n[4:1]) ? DISABLE : first_wr(mask_n);
      DISABLE:  state_nxt = first_wr(mask_q);
      WR_INT:   state_nxt = first_wr(mask_q & 5'b11101);
      WR_M1:    state_nxt = first_wr(mask_q & 5'b11001);
      WR_M2:    state_nxt = first_wr(mask_q & 5'b10001);
      WR_M3:    state_nxt = first_wr(mask_q & 5'b00001);
      WR_CTRL:  state_nxt = ctrl_q[4] ? WAIT_RST : DONE;
      // A cleared restart bit wins over a timeout landing on the same cycle.
      WAIT_RST: if (!cntr_ctrl_reg_in6[4] || tmo_cnt == TIMEOUT - 8'd1) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobe and data for the state being entered, so they are registered.
  always_comb begin
    sel_n  = '0;
    data_n = '0;
    case (state_nxt)
      DISABLE: begin
        sel_n[0] = 1'b1;
        data_n   = {9'd0, (cntr_ctrl_reg_in6 | 7'h01) & 7'h6F};
      end
      WR_INT:  begin sel_n[1] = 1'b1; data_n = int_n; end
      WR_M1:   begin sel_n[2] = 1'b1; data_n = m1_n;  end
      WR_M2:   begin sel_n[3] = 1'b1; data_n = m2_n;  end
      WR_M3:   begin sel_n[4] = 1'b1; data_n = m3_n;  end
      WR_CTRL: begin sel_n[0] = 1'b1; data_n = {9'd0, ctrl_n}; end
      default: ;
    endcase
  end

  always_ff @(posedge pclk6 or negedge n_p_reset6) begin
    if (!n_p_reset6) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      win_q   <= 1'b0;
      mask_q  <= '0;
      ctrl_q  <= '0;
      int_q   <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      tmo_cnt <= '0;
      sel_q   <= '0;
      pwdata6 <= '0;
      gnt6    <= '0;
      done6   <= '0;
      err6    <= 1'b0;
      busy6   <= 1'b0;
    end else begin
      state   <= state_nxt;
      win_q   <= win_n;
      mask_q  <= mask_n;
      ctrl_q  <= ctrl_n;
      int_q   <= int_n;
      m1_q    <= m1_n;
      m2_q    <= m2_n;
      m3_q    <= m3_n;
      tmo_cnt <= (state == WAIT_RST) ? tmo_cnt + 8'd1 : 8'd0;
      sel_q   <= sel_n;
      pwdata6 <= data_n;
      busy6   <= (state_nxt != IDLE);
      // Pointer moves to the requester that did not win.
      if (state == IDLE && |req6) begin
        ptr  <= ~win_n;
        gnt6 <= win_n ? 2'b10 : 2'b01;
      end else begin
        gnt6 <= 2'b00;
      end
      done6 <= (state_nxt == DONE) ? (win_n ? 2'b10 : 2'b01) : 2'b00;
      err6  <= (state == WAIT_RST) && (state_nxt == DONE) && cntr_ctrl_reg_in6[4];
    end
  end

  assign cntr_ctrl_reg_sel6 = sel_q[0];
  assign interval_reg_sel6  = sel_q[1];
  assign match_1_reg_sel6   = sel_q[2];
  assign match_2_reg_sel6   = sel_q[3];
  assign match_3_reg_sel6   = sel_q[4];

endmodule

// File: tb/tb_ttc_cfg_sequencer6.sv
// Bench for ttc_cfg_sequencer6. A transaction-level model turns each grant
// into a list of per-cycle expected outputs (writes, restart wait, done) and
// a small counter model drives the control readback.
module tb_ttc_cfg_sequencer6;
  localparam logic [7:0] TMO = 8'd8;

  logic pclk6 = 1'b0;
  logic n_p_reset6 = 1'b0;
  logic [1:0] req6 = 2'b00;
  logic [6:0] rb = 7'h00;

  logic [4:0]  p_mask[2];
  logic [6:0]  p_ctrl[2];
  logic [15:0] p_val[2][4];

  logic [4:0]  cfg_mask0_6, cfg_mask1_6;
  logic [6:0]  cfg_ctrl0_6, cfg_ctrl1_6;
  logic [15:0] cfg_int0_6, cfg_m1_0_6, cfg_m2_0_6, cfg_m3_0_6;
  logic [15:0] cfg_int1_6, cfg_m1_1_6, cfg_m2_1_6, cfg_m3_1_6;
  assign cfg_mask0_6 = p_mask[0];
  assign cfg_mask1_6 = p_mask[1];
  assign cfg_ctrl0_6 = p_ctrl[0];
  assign cfg_ctrl1_6 = p_ctrl[1];
  assign cfg_int0_6  = p_val[0][0];
  assign cfg_m1_0_6  = p_val[0][1];
  assign cfg_m2_0_6  = p_val[0][2];
  assign cfg_m3_0_6  = p_val[0][3];
  assign cfg_int1_6  = p_val[1][0];
  assign cfg_m1_1_6  = p_val[1][1];
  assign cfg_m2_1_6  = p_val[1][2];
  assign cfg_m3_1_6  = p_val[1][3];

  logic [15:0] pwdata6;
  logic cntr_ctrl_reg_sel6, interval_reg_sel6, match_1_reg_sel6, match_2_reg_sel6, match_3_reg_sel6;
  logic [1:0] gnt6, done6;
  logic err6, busy6;

  ttc_cfg_sequencer6 #(.TIMEOUT(TMO)) dut (
    .pclk6(pclk6), .n_p_reset6(n_p_reset6), .req6(req6),
    .cfg_mask0_6(cfg_mask0_6), .cfg_mask1_6(cfg_mask1_6),
    .cfg_ctrl0_6(cfg_ctrl0_6), .cfg_ctrl1_6(cfg_ctrl1_6),
    .cfg_int0_6(cfg_int0_6), .cfg_m1_0_6(cfg_m1_0_6), .cfg_m2_0_6(cfg_m2_0_6), .cfg_m3_0_6(cfg_m3_0_6),
    .cfg_int1_6(cfg_int1_6), .cfg_m1_1_6(cfg_m1_1_6), .cfg_m2_1_6(cfg_m2_1_6), .cfg_m3_1_6(cfg_m3_1_6),
    .cntr_ctrl_reg_in6(rb), .pwdata6(pwdata6),
    .cntr_ctrl_reg_sel6(cntr_ctrl_reg_sel6), .interval_reg_sel6(interval_reg_sel6),
    .match_1_reg_sel6(match_1_reg_sel6), .match_2_reg_sel6(match_2_reg_sel6),
    .match_3_reg_sel6(match_3_reg_sel6),
    .gnt6(gnt6), .done6(done6), .err6(err6), .busy6(busy6)
  );

  always #5 pclk6 = ~pclk6;

  // {busy, err, done[1:0], gnt[1:0], sel m3..ctrl, pwdata}
  logic [26:0] obs;
  assign obs = {busy6, err6, done6, gnt6, match_3_reg_sel6, match_2_reg_sel6,
                match_1_reg_sel6, interval_reg_sel6, cntr_ctrl_reg_sel6, pwdata6};

  int n_chk = 0;
  int n_pass = 0;
  logic [26:0] exp_q[$];
  bit          mark_q[$];
  bit   ptr_m = 1'b0;
  int   win_m = 0;
  int   next_k = 1;
  int   restart_k = 1;
  int   rst_cnt = 0;
  int   txn = 0;
  int   cyc = 0;
  bit   auto_req = 1'b0;
  logic [4:0] last_sel = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic logic [26:0] ev(input logic busy, input logic err, input logic [1:0] dn,
                                     input logic [4:0] sel, input logic [15:0] d);
    return {busy, err, dn, 2'b00, sel, d};
  endfunction

  task automatic new_packet(input int r);
    p_mask[r] = 5'($urandom);
    p_ctrl[r] = 7'($urandom);
    for (int i = 0; i < 4; i++) p_val[r][i] = 16'($urandom);
  endtask

  // Predict every cycle from the grant through DONE for the current winner.
  task automatic build();
    int w;
    int waits;
    logic [6:0] dis;
    logic [26:0] e;
    w = (req6 == 2'b11) ? int'(ptr_m) : (req6[1] ? 1 : 0);
    ptr_m = (w == 0);
    win_m = w;
    restart_k = next_k;
    txn++;
    exp_q.delete();
    mark_q.delete();
    if (p_mask[w][4:1] != 4'd0) begin
      dis = rb;
      dis[0] = 1'b1;
      dis[4] = 1'b0;
      exp_q.push_back(ev(1'b1, 1'b0, 2'b00, 5'b00001, {9'd0, dis}));
      mark_q.push_back(1'b0);
    end
    for (int i = 1; i <= 4; i++) begin
      if (p_mask[w][i]) begin
        exp_q.push_back(ev(1'b1, 1'b0, 2'b00, 5'(1 << i), p_val[w][i-1]));
        mark_q.push_back(1'b0);
      end
    end
    waits = 0;
    if (p_mask[w][0]) begin
      exp_q.push_back(ev(1'b1, 1'b0, 2'b00, 5'b00001, {9'd0, p_ctrl[w]}));
      mark_q.push_back(p_ctrl[w][4]);
      if (p_ctrl[w][4]) waits = (restart_k < int'(TMO)) ? restart_k : int'(TMO);
    end
    for (int i = 0; i < waits; i++) begin
      exp_q.push_back(ev(1'b1, 1'b0, 2'b00, 5'b00000, 16'h0000));
      mark_q.push_back(1'b0);
    end
    exp_q.push_back(ev(1'b1, (waits > 0) && (restart_k > int'(TMO)), (w == 1) ? 2'b10 : 2'b01,
                       5'b00000, 16'h0000));
    mark_q.push_back(1'b0);
    e = exp_q[0];
    e[22:21] = (w == 1) ? 2'b10 : 2'b01;
    exp_q[0] = e;
  endtask

  task automatic raise_random();
    for (int r = 0; r < 2; r++) begin
      if (!req6[r] && $urandom_range(0, 2) != 0) begin
        new_packet(r);
        req6[r] = 1'b1;
      end
    end
  endtask

  // One call per negedge: counter model, compare, then stimulus for next edge.
  task automatic cycle_check();
    logic [26:0] e;
    bit m;
    cyc++;
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) rb[4] = 1'b0;
    end
    if (auto_req) raise_random();
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      m = mark_q.pop_front();
      last_sel = e[20:16];
      chk($sformatf("txn%0d_cyc%0d", txn, cyc), {5'd0, obs}, {5'd0, e});
      if (e[22:21] != 2'b00) new_packet(win_m);
      if (m) begin
        rb[4] = 1'b1;
        rst_cnt = restart_k;
      end
      if (e[24:23] != 2'b00) req6[win_m] = 1'b0;
    end else begin
      last_sel = '0;
      chk($sformatf("idle_cyc%0d", cyc), {5'd0, obs}, 32'd0);
      if (auto_req && rst_cnt == 0) rb = 7'($urandom);
      if (auto_req) next_k = $urandom_range(1, 12);
      if (req6 != 2'b00) build();
    end
  endtask

  task automatic drain(input bit rst_m2);
    int n;
    bit fired;
    n = 0;
    fired = 1'b0;
    do begin
      @(negedge pclk6);
      cycle_check();
      n++;
      if (rst_m2 && !fired && last_sel == 5'b01000) begin
        fired = 1'b1;
        #2 n_p_reset6 = 1'b0;
        #1 chk("rst_mid_outputs", {5'd0, obs}, 32'd0);
        exp_q.delete();
        mark_q.delete();
        ptr_m = 1'b0;
        @(negedge pclk6);
        chk("rst_hold_outputs", {5'd0, obs}, 32'd0);
        n_p_reset6 = 1'b1;
        cycle_check();
      end
    end while ((exp_q.size() != 0 || req6 != 2'b00) && n < 300);
    chk("drain_complete", {31'd0, (exp_q.size() == 0 && req6 == 2'b00)}, 32'd1);
    if (rst_m2) chk("rst_mid_fired", {31'd0, fired}, 32'd1);
  endtask

  task automatic set_pkt(input int r, input logic [4:0] mk, input logic [6:0] c,
                         input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3);
    p_mask[r] = mk;
    p_ctrl[r] = c;
    p_val[r][0] = v0;
    p_val[r][1] = v1;
    p_val[r][2] = v2;
    p_val[r][3] = v3;
  endtask

  initial begin
    set_pkt(0, 5'b11111, 7'b0001010, 16'h0010, 16'h0003, 16'h0005, 16'h0007);
    set_pkt(1, 5'b10011, 7'h03, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    rb = 7'h5A;
    req6 = 2'b11;
    #2 chk("reset_outputs", {5'd0, obs}, 32'd0);
    @(negedge pclk6);
    chk("reset_outputs_held", {5'd0, obs}, 32'd0);
    n_p_reset6 = 1'b1;
    cycle_check();
    drain(1'b0);

    // Both again: pointer must be back on requester 0.
    @(negedge pclk6);
    set_pkt(0, 5'b01010, 7'h21, 16'hAAAA, 16'h1111, 16'h2222, 16'h3333);
    set_pkt(1, 5'b00001, 7'h45, 16'h0, 16'h0, 16'h0, 16'h0);
    req6 = 2'b11;
    cycle_check();
    drain(1'b0);

    // Restart consumed after 5 cycles.
    @(negedge pclk6);
    set_pkt(0, 5'b00001, 7'b0010110, 16'h0, 16'h0, 16'h0, 16'h0);
    next_k = 5;
    req6 = 2'b01;
    cycle_check();
    drain(1'b0);

    // Restart bit stuck high past the timeout.
    @(negedge pclk6);
    set_pkt(1, 5'b00011, 7'b0010001, 16'h4321, 16'h0, 16'h0, 16'h0);
    next_k = 40;
    req6 = 2'b10;
    cycle_check();
    drain(1'b0);

    // Sparse mask: match1 only.
    @(negedge pclk6);
    set_pkt(0, 5'b00100, 7'h7F, 16'h0, 16'hBEEF, 16'h0, 16'h0);
    req6 = 2'b01;
    cycle_check();
    drain(1'b0);

    // Empty mask.
    @(negedge pclk6);
    set_pkt(1, 5'b00000, 7'h10, 16'h1, 16'h2, 16'h3, 16'h4);
    req6 = 2'b10;
    cycle_check();
    drain(1'b0);

    // Reset during WR_M2; requester 0 keeps requesting and is re-granted.
    @(negedge pclk6);
    set_pkt(0, 5'b11111, 7'h0B, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    req6 = 2'b01;
    cycle_check();
    drain(1'b1);

    // Randomised traffic, including requests raised while busy.
    auto_req = 1'b1;
    repeat (600) begin
      @(negedge pclk6);
      cycle_check();
    end
    auto_req = 1'b0;
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
